// File: rtl/simd_pkg.sv
// Shared definitions for the matrix-multiply output path: stream FSM encoding
// and the default streamed element width used by the downstream writer.
package simd_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_e;

  localparam int W_STR_DEFAULT = 16;

endpackage

// File: rtl/mat_elem_sat.sv
// Combinational signed W_OUT -> W_STR element converter.
// MAT_STREAM_SAT_EN selects saturation; otherwise the low W_STR bits are kept.
module mat_elem_sat #(
  parameter int W_OUT = 32,
  parameter int W_STR = 16
) (
  input  logic [W_OUT-1:0] din,
  output logic [W_STR-1:0] dout
);

  // Bits that must all equal the sign for the value to fit in W_STR.
  logic [W_OUT-W_STR:0] top_s;
  assign top_s = din[W_OUT-1 -: W_OUT-W_STR+1];

`ifdef MAT_STREAM_SAT_EN
  logic fits_s;
  assign fits_s = (top_s == {(W_OUT-W_STR+1){din[W_OUT-1]}});

  always_comb begin
    dout = din[W_STR-1:0];
    if (fits_s) begin
      dout = din[W_STR-1:0];
    end else if (din[W_OUT-1]) begin
      dout = {1'b1, {(W_STR-1){1'b0}}};
    end else begin
      dout = {1'b0, {(W_STR-1){1'b1}}};
    end
  end
`else
  logic unused_top_s;
  assign unused_top_s = ^top_s;
  assign dout = din[W_STR-1:0];
`endif

endmodule

// File: rtl/mat_result_streamer.sv
// Captures a flat NxN result on valid_in and streams it row-major on a
// valid/ready port with row/matrix end markers. Optional macro: MAT_STREAM_SAT_EN.
module mat_result_streamer
  import simd_pkg::*;
#(
  parameter int W_OUT = 32,
  parameter int W_STR = W_STR_DEFAULT,
  parameter int N     = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid_in,
  input  logic [N*N*W_OUT-1:0]   result,
  output logic                   in_ready,
  output logic                   overrun,
  output logic [W_STR-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_row_last,
  output logic                   m_last
);

  localparam int NN = N * N;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NN - 1);

  stream_state_e          state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [NN*W_OUT-1:0]    hold_q, hold_d;
  logic                   overrun_q, overrun_d;
  logic [W_STR-1:0]       m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_row_last_q, m_row_last_d;
  logic                   m_last_q, m_last_d;

  logic                   capture_s;
  logic                   stream_s;
  logic [W_OUT-1:0]       elem_s;
  logic [W_STR-1:0]       conv_s;

  // The final beat can hand over to a new matrix in the same cycle.
  assign in_ready  = (state_q == ST_IDLE) | (m_ready & m_last_q);
  assign capture_s = valid_in & in_ready;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    hold_d    = hold_q;
    overrun_d = overrun_q | (valid_in & ~in_ready);

    case (state_q)
      ST_IDLE: begin
        if (capture_s) begin
          hold_d  = result;
          k_d     = '0;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (m_ready) begin
          if (k_q == K_LAST) begin
            if (capture_s) begin
              hold_d = result;
              k_d    = '0;
            end else begin
              k_d     = '0;
              state_d = ST_IDLE;
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          k_d = k_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase

    // Outputs are precomputed from the next hold/counter so they register cleanly.
    stream_s     = (state_d == ST_STREAM);
    elem_s       = hold_d[32'(k_d) * W_OUT +: W_OUT];
    m_valid_d    = stream_s;
    m_data_d     = stream_s ? conv_s : '0;
    m_last_d     = stream_s && (k_d == K_LAST);
    m_row_last_d = stream_s && ((32'(k_d) % N) == (N - 1));
  end

  mat_elem_sat #(
    .W_OUT (W_OUT),
    .W_STR (W_STR)
  ) u_conv (
    .din  (elem_s),
    .dout (conv_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      hold_q       <= '0;
      overrun_q    <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_row_last_q <= 1'b0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      hold_q       <= hold_d;
      overrun_q    <= overrun_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_row_last_q <= m_row_last_d;
      m_last_q     <= m_last_d;
    end
  end

  assign overrun    = overrun_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_row_last = m_row_last_q;
  assign m_last     = m_last_q;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer with N=2, W_OUT=32, W_STR=16.
module tb_mat_result_streamer;

  localparam int N     = 2;
  localparam int W_OUT = 32;
  localparam int W_STR = 16;

  logic                 clk;
  logic                 rstn;
  logic                 valid_in;
  logic [N*N*W_OUT-1:0] result;
  logic                 in_ready;
  logic                 overrun;
  logic [W_STR-1:0]     m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_row_last;
  logic                 m_last;

  int checks;
  int failures;

  mat_result_streamer #(
    .W_OUT (W_OUT),
    .W_STR (W_STR),
    .N     (N)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .result     (result),
    .in_ready   (in_ready),
    .overrun    (overrun),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_row_last (m_row_last),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*N*W_OUT-1:0] pack4(input int e0, input int e1,
                                                 input int e2, input int e3);
    logic [N*N*W_OUT-1:0] v;
    v = {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [15:0] d, input logic rl, input logic l);
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_data"}, 32'(m_data), 32'(d));
    chk({tag, "_rowlast"}, 32'(m_row_last), 32'(rl));
    chk({tag, "_last"}, 32'(m_last), 32'(l));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_last"}, 32'(m_last), 32'd0);
    chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic capture(input logic [N*N*W_OUT-1:0] data);
    valid_in = 1'b1;
    result   = data;
    step();
    valid_in = 1'b0;
    result   = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    valid_in = 1'b0;
    result   = '0;
    m_ready  = 1'b1;

    // Reset state
    #2;
    chk("rst_inrdy", 32'(in_ready), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_rowlast", 32'(m_row_last), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    step();
    step();
    rstn = 1'b1;
    step();

    // Basic ordering
    capture(pack4(1, -2, 3, -4));
    beat("ord0", 16'h0001, 1'b0, 1'b0);
    chk("ord0_inrdy", 32'(in_ready), 32'd0);
    step();
    beat("ord1", 16'hFFFE, 1'b1, 1'b0);
    step();
    beat("ord2", 16'h0003, 1'b0, 1'b0);
    step();
    beat("ord3", 16'hFFFC, 1'b1, 1'b1);
    chk("ord3_inrdy", 32'(in_ready), 32'd1);
    step();
    idle_chk("ord_end");
    chk("ord_end_data", 32'(m_data), 32'd0);

    // Backpressure on beat 1
    capture(pack4(1, -2, 3, -4));
    beat("bp0", 16'h0001, 1'b0, 1'b0);
    step();
    m_ready = 1'b0;
    beat("bp1_hold0", 16'hFFFE, 1'b1, 1'b0);
    chk("bp_inrdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      beat("bp1_hold", 16'hFFFE, 1'b1, 1'b0);
    end
    m_ready = 1'b1;
    beat("bp1_go", 16'hFFFE, 1'b1, 1'b0);
    step();
    beat("bp2", 16'h0003, 1'b0, 1'b0);
    step();
    beat("bp3", 16'hFFFC, 1'b1, 1'b1);
    step();
    idle_chk("bp_end");

    // Back-to-back matrices with no bubble
    capture(pack4(1, -2, 3, -4));
    beat("b2b0", 16'h0001, 1'b0, 1'b0);
    step();
    beat("b2b1", 16'hFFFE, 1'b1, 1'b0);
    step();
    beat("b2b2", 16'h0003, 1'b0, 1'b0);
    step();
    beat("b2b3", 16'hFFFC, 1'b1, 1'b1);
    chk("b2b3_inrdy", 32'(in_ready), 32'd1);
    capture(pack4(5, 6, 7, 8));
    beat("b2b4", 16'h0005, 1'b0, 1'b0);
    step();
    beat("b2b5", 16'h0006, 1'b1, 1'b0);
    step();
    beat("b2b6", 16'h0007, 1'b0, 1'b0);
    step();
    beat("b2b7", 16'h0008, 1'b1, 1'b1);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    step();
    idle_chk("b2b_end");

    // Overrun: pulse during beat 1 is discarded
    capture(pack4(1, -2, 3, -4));
    beat("ovr0", 16'h0001, 1'b0, 1'b0);
    step();
    beat("ovr1", 16'hFFFE, 1'b1, 1'b0);
    chk("ovr1_inrdy", 32'(in_ready), 32'd0);
    capture(pack4(9, 9, 9, 9));
    chk("ovr_set", 32'(overrun), 32'd1);
    beat("ovr2", 16'h0003, 1'b0, 1'b0);
    step();
    beat("ovr3", 16'hFFFC, 1'b1, 1'b1);
    step();
    idle_chk("ovr_end");
    capture(pack4(5, 6, 7, 8));
    beat("ovr_cap0", 16'h0005, 1'b0, 1'b0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    step();
    beat("ovr_cap1", 16'h0006, 1'b1, 1'b0);
    step();
    beat("ovr_cap2", 16'h0007, 1'b0, 1'b0);
    step();
    beat("ovr_cap3", 16'h0008, 1'b1, 1'b1);
    step();
    idle_chk("ovr_cap_end");

    // Conversion of out-of-range and boundary elements
    capture(pack4(74565, -40000, 32767, -32768));
`ifdef MAT_STREAM_SAT_EN
    beat("cnv0", 16'h7FFF, 1'b0, 1'b0);
    step();
    beat("cnv1", 16'h8000, 1'b1, 1'b0);
`else
    beat("cnv0", 16'h2345, 1'b0, 1'b0);
    step();
    beat("cnv1", 16'h63C0, 1'b1, 1'b0);
`endif
    step();
    beat("cnv2", 16'h7FFF, 1'b0, 1'b0);
    step();
    beat("cnv3", 16'h8000, 1'b1, 1'b1);
    step();
    idle_chk("cnv_end");

    // Reset during beat 2
    capture(pack4(1, -2, 3, -4));
    step();
    step();
    beat("mrst2", 16'h0003, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mrst_valid", 32'(m_valid), 32'd0);
    chk("mrst_data", 32'(m_data), 32'd0);
    chk("mrst_rowlast", 32'(m_row_last), 32'd0);
    chk("mrst_last", 32'(m_last), 32'd0);
    chk("mrst_inrdy", 32'(in_ready), 32'd1);
    chk("mrst_overrun", 32'(overrun), 32'd0);
    step();
    rstn = 1'b1;
    step();
    idle_chk("mrst_rel");
    chk("mrst_rel_overrun", 32'(overrun), 32'd0);
    capture(pack4(5, 6, 7, 8));
    beat("mrst_cap0", 16'h0005, 1'b0, 1'b0);
    step();
    beat("mrst_cap1", 16'h0006, 1'b1, 1'b0);
    step();
    beat("mrst_cap2", 16'h0007, 1'b0, 1'b0);
    step();
    beat("mrst_cap3", 16'h0008, 1'b1, 1'b1);
    step();
    idle_chk("mrst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
